// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
// LT_* values must match the downstream load sign extender.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        DONE,
        ERR
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] LT_NONE = 2'd0;
    localparam logic [1:0] LT_BYTE = 2'd1;
    localparam logic [1:0] LT_HALF = 2'd2;

    // funct3[1:0] encodes access size for every legal load and store
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and store shifting one way,
// load data realignment and zero-padding the other.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  is_load,
    input  logic [2:0]            funct3,
    input  logic [1:0]            off,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [3:0]            be,
    output logic [DATA_WIDTH-1:0] wdata_sh,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata_al,
    output logic [1:0]            load_type
);

    logic                  legal;
    logic                  misaligned;
    logic [3:0]            base;
    logic [DATA_WIDTH-1:0] lane_mask;

    always_comb begin
        if (is_load) begin
            legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end else begin
            legal = funct3 inside {F3_B, F3_H, F3_W};
        end

        case (funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            default: misaligned = |off;
        endcase
        err = !legal || misaligned;

        base      = size_mask(funct3[1:0]);
        be        = base << off;
        lane_mask = {{8{base[3]}}, {8{base[2]}}, {8{base[1]}}, {8{base[0]}}};

        // loads never drive write lanes
        wdata_sh = is_load ? '0 : ((wdata & lane_mask) << {off, 3'b000});
        rdata_al = (rdata >> {off, 3'b000}) & lane_mask;

        case (funct3)
            F3_B:    load_type = LT_BYTE;
            F3_H:    load_type = LT_HALF;
            default: load_type = LT_NONE;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage unit: takes one load/store from execute, issues one word-aligned
// req/gnt/rvalid bus transaction and returns aligned, zero-padded load data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic                      ex_is_load,
    input  logic                      ex_is_store,
    input  logic [2:0]                ex_funct3,
    input  logic [DATA_WIDTH-1:0]     ex_addr,
    input  logic [DATA_WIDTH-1:0]     ex_wdata,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      mem_req,
    input  logic                      mem_gnt,
    output logic                      mem_we,
    output logic [DATA_WIDTH-1:0]     mem_addr,
    output logic [3:0]                mem_be,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_rvalid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      wb_valid,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic [1:0]                wb_load_type,
    output logic                      misalign_err
);

    lsu_state_t                state_q, state_d;
    logic [2:0]                f3_q, f3_d;
    logic [DATA_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      is_load_q, is_load_d;
    logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
    logic [1:0]                wb_lt_q, wb_lt_d;

    logic                  in_idle;
    logic                  accept;
    logic                  al_is_load;
    logic [2:0]            al_f3;
    logic [1:0]            al_off;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [3:0]            al_be;
    logic [DATA_WIDTH-1:0] al_wdata_sh;
    logic                  al_err;
    logic [DATA_WIDTH-1:0] al_rdata;
    logic [1:0]            al_lt;

    assign in_idle = (state_q == IDLE);
    assign accept  = ex_valid && in_idle && (ex_is_load || ex_is_store);

    // One aligner serves both phases: it checks the incoming op while idle,
    // then steers the captured op during the bus transaction.
    assign al_is_load = in_idle ? ex_is_load      : is_load_q;
    assign al_f3      = in_idle ? ex_funct3       : f3_q;
    assign al_off     = in_idle ? ex_addr[1:0]    : addr_q[1:0];
    assign al_wdata   = in_idle ? ex_wdata        : wdata_q;

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .is_load   (al_is_load),
        .funct3    (al_f3),
        .off       (al_off),
        .wdata     (al_wdata),
        .rdata     (mem_rdata),
        .be        (al_be),
        .wdata_sh  (al_wdata_sh),
        .err       (al_err),
        .rdata_al  (al_rdata),
        .load_type (al_lt)
    );

    always_comb begin
        state_d   = state_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        is_load_d = is_load_q;
        wb_data_d = wb_data_q;
        wb_lt_d   = wb_lt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    f3_d      = ex_funct3;
                    addr_d    = ex_addr;
                    wdata_d   = ex_wdata;
                    rd_d      = ex_rd;
                    is_load_d = ex_is_load;
                    state_d   = ((ex_is_load && ex_is_store) || al_err) ? ERR : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = is_load_q ? RESP : IDLE;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    wb_data_d = al_rdata;
                    wb_lt_d   = al_lt;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers are only observed through state-gated outputs.
    always_ff @(posedge clk) begin
        f3_q      <= f3_d;
        addr_q    <= addr_d;
        wdata_q   <= wdata_d;
        rd_q      <= rd_d;
        is_load_q <= is_load_d;
        wb_data_q <= wb_data_d;
        wb_lt_q   <= wb_lt_d;
    end

    assign ex_ready     = in_idle;
    assign mem_req      = (state_q == REQ);
    assign mem_we       = mem_req && !is_load_q;
    assign mem_addr     = mem_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
    assign mem_be       = mem_req ? al_be : '0;
    assign mem_wdata    = mem_req ? al_wdata_sh : '0;
    assign wb_valid     = (state_q == DONE);
    assign wb_rd        = wb_valid ? rd_q : '0;
    assign wb_data      = wb_valid ? wb_data_q : '0;
    assign wb_load_type = wb_valid ? wb_lt_q : '0;
    assign misalign_err = (state_q == ERR);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// ops compared against an arithmetic reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        mem_req, mem_gnt, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_load_type;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_load_type(wb_load_type), .misalign_err(misalign_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---- reference model: plain arithmetic from the access rules ----
    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit m_err(input bit ld, input bit st, input logic [2:0] f3, input logic [1:0] off);
        bit legal;
        if (ld && st) return 1'b1;
        if (ld) legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        else    legal = (f3 == 0 || f3 == 1 || f3 == 2);
        if (!legal) return 1'b1;
        return (int'(off) % m_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] m_mask(input int sz);
        longint one = 1;
        return 32'((one << (8 * sz)) - 1);
    endfunction

    function automatic logic [3:0] m_be(input int sz, input logic [1:0] off);
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [1:0] m_type(input logic [2:0] f3);
        if (f3 == 3'd0) return 2'd1;
        if (f3 == 3'd1) return 2'd2;
        return 2'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one op starting in IDLE and check every cycle until it is back in IDLE.
    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rdata);
        int          sz = m_size(f3);
        logic [1:0]  off = addr[1:0];
        logic [31:0] exp_wd = (wdata & m_mask(sz)) << (8 * off);
        logic [31:0] exp_ld = (rdata >> (8 * off)) & m_mask(sz);
        check("ready_before_op", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
        ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
        tick();
        ex_valid = 1'b0; ex_is_load = 1'($urandom); ex_is_store = 1'($urandom);
        ex_funct3 = 3'($urandom); ex_addr = $urandom; ex_wdata = $urandom; ex_rd = 5'($urandom);
        if (m_err(ld, st, f3, off)) begin
            check("err_pulse", 32'(misalign_err), 32'd1);
            check("err_no_req", 32'(mem_req), 32'd0);
            check("err_not_ready", 32'(ex_ready), 32'd0);
            tick();
            check("err_one_cycle", 32'(misalign_err), 32'd0);
            check("err_no_req2", 32'(mem_req), 32'd0);
            check("err_ready_back", 32'(ex_ready), 32'd1);
            return;
        end
        for (int c = 0; c <= gnt_dly; c++) begin
            if (c == gnt_dly) mem_gnt = 1'b1;
            check("req", 32'(mem_req), 32'd1);
            check("we", 32'(mem_we), 32'(st));
            check("addr", mem_addr, {addr[31:2], 2'b00});
            check("be", 32'(mem_be), 32'(m_be(sz, off)));
            if (st) check("wdata", mem_wdata, exp_wd);
            check("no_wb_in_req", 32'(wb_valid), 32'd0);
            tick();
        end
        mem_gnt = 1'b0;
        check("req_dropped", 32'(mem_req), 32'd0);
        if (st) begin
            check("store_ready_after_gnt", 32'(ex_ready), 32'd1);
            check("store_no_wb", 32'(wb_valid), 32'd0);
            return;
        end
        for (int c = 0; c < rv_dly; c++) begin
            check("resp_wait_no_wb", 32'(wb_valid), 32'd0);
            check("resp_not_ready", 32'(ex_ready), 32'd0);
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0; mem_rdata = $urandom;
        check("wb_valid", 32'(wb_valid), 32'd1);
        check("wb_data", wb_data, exp_ld);
        check("wb_rd", 32'(wb_rd), 32'(rd));
        check("wb_type", 32'(wb_load_type), 32'(m_type(f3)));
        tick();
        check("wb_one_cycle", 32'(wb_valid), 32'd0);
        check("ready_after_load", 32'(ex_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
        ex_funct3 = '0; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick();
        tick();
        check("rst_ready", 32'(ex_ready), 32'd1);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_err", 32'(misalign_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // directed cases
        run_op(1, 0, 3'b000, 32'h0000_1003, 32'h0, 5'd3, 0, 0, 32'h80AA_BBCC);
        run_op(1, 0, 3'b101, 32'h0000_2002, 32'h0, 5'd4, 0, 1, 32'hF00D_1234);
        run_op(1, 0, 3'b001, 32'h0000_2002, 32'h0, 5'd5, 2, 0, 32'hF00D_1234);
        run_op(0, 1, 3'b000, 32'h0000_3001, 32'h0000_00EE, 5'd0, 3, 0, 32'h0);
        run_op(1, 0, 3'b010, 32'h0000_4002, 32'h0, 5'd6, 0, 0, 32'h0);
        run_op(1, 1, 3'b010, 32'h0000_4000, 32'h0, 5'd6, 0, 0, 32'h0);
        run_op(0, 1, 3'b100, 32'h0000_4000, 32'h0, 5'd6, 0, 0, 32'h0);

        // valid without load/store is not accepted
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b0;
        tick();
        ex_valid = 1'b0;
        check("nop_ready", 32'(ex_ready), 32'd1);
        check("nop_no_req", 32'(mem_req), 32'd0);
        check("nop_no_err", 32'(misalign_err), 32'd0);

        // reset while waiting for read data
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0;
        ex_funct3 = 3'b010; ex_addr = 32'h0000_5000; ex_rd = 5'd7;
        tick();
        ex_valid = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("resp_entered", 32'(ex_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", 32'(ex_ready), 32'd1);
        check("async_rst_req", 32'(mem_req), 32'd0);
        check("async_rst_wb", 32'(wb_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        check("stale_rvalid_no_wb", 32'(wb_valid), 32'd0);
        check("stale_rvalid_ready", 32'(ex_ready), 32'd1);
        tick();
        check("stale_rvalid_no_wb2", 32'(wb_valid), 32'd0);
        run_op(1, 0, 3'b010, 32'h0000_6000, 32'h0, 5'd9, 0, 0, 32'h1234_5678);

        // randomized ops
        for (int i = 0; i < 120; i++) begin
            bit ld, st;
            int pick = $urandom_range(0, 15);
            ld = (pick < 8) || (pick == 15);
            st = (pick >= 8);
            run_op(ld, st, 3'($urandom), $urandom, $urandom, 5'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
